// File: rtl/pipe_control.sv
// pipe_control: E/M/W control pipeline; HAZARD_STALL_EN adds load-use stall and stall counter
module pipe_control #(
  parameter int OPCODEWIDTH   = 4,
  parameter int REGADDRWIDTH  = 4,
  parameter int STALLCNTWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OPCODEWIDTH-1:0]   opcodeD,
  input  logic [REGADDRWIDTH-1:0]  rdD,
  input  logic [REGADDRWIDTH-1:0]  rs1D,
  input  logic [REGADDRWIDTH-1:0]  rs2D,
  input  logic                     flushE,
  output logic [2:0]               aluControlE,
  output logic                     data2SelectorE,
  output logic                     writeDataEnableM,
  output logic                     outFlagM,
  output logic                     resultSelectorW,
  output logic                     writeEnableW,
  output logic [REGADDRWIDTH-1:0]  rdE,
  output logic [REGADDRWIDTH-1:0]  rdM,
  output logic [REGADDRWIDTH-1:0]  rdW,
  output logic                     validE,
  output logic                     validM,
  output logic                     validW,
  output logic                     stallD,
  output logic [STALLCNTWIDTH-1:0] stallCount
);
  // bundle layout: {we, src, alu[2:0], mwe, wbsel, out}
  logic [7:0]              ctrl_d, ctrl_e_d, ctrl_e_q;
  logic [REGADDRWIDTH-1:0] rd_e_d, rd_e_q, rd_m_q, rd_w_q;
  logic                    valid_e_d, valid_e_q, valid_m_q, valid_w_q;
  logic                    we_m_q, mwe_m_q, wbsel_m_q, out_m_q, we_w_q, wbsel_w_q;
  // opcode decode; anything with bits above bit 3 set is a NOP
  always_comb begin
    ctrl_d = 8'h00;
    if (~|(opcodeD >> 4))
      case (opcodeD[3:0])
        4'h0:    ctrl_d = 8'b0_0_000_0_0_0;
        4'h1:    ctrl_d = 8'b0_0_110_1_0_0;
        4'h2:    ctrl_d = 8'b1_1_111_0_0_0;
        4'h3:    ctrl_d = 8'b1_0_110_0_0_0;
        4'h4:    ctrl_d = 8'b0_0_110_0_0_1;
        4'h5:    ctrl_d = 8'b1_0_000_0_0_0;
        4'h6:    ctrl_d = 8'b1_0_001_0_0_0;
        4'h7:    ctrl_d = 8'b1_0_110_0_1_0;
        4'h8:    ctrl_d = 8'b1_0_010_0_0_0;
        4'h9:    ctrl_d = 8'b1_0_101_0_0_0;
        4'hA:    ctrl_d = 8'b0_0_001_0_0_0;
        default: ctrl_d = 8'b0_1_111_0_0_0;
      endcase
  end
  // E-stage next state: a bubble on flush or stall, otherwise the decoded instruction
  always_comb begin
    ctrl_e_d  = (flushE | stallD) ? 8'h00 : ctrl_d;
    rd_e_d    = (flushE | stallD) ? '0 : rdD;
    valid_e_d = ~(flushE | stallD);
  end
  // E, M, W pipeline registers; M and W always advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_q  <= 8'h00;
      rd_e_q    <= '0;
      valid_e_q <= 1'b0;
      we_m_q    <= 1'b0;
      mwe_m_q   <= 1'b0;
      wbsel_m_q <= 1'b0;
      out_m_q   <= 1'b0;
      rd_m_q    <= '0;
      valid_m_q <= 1'b0;
      we_w_q    <= 1'b0;
      wbsel_w_q <= 1'b0;
      rd_w_q    <= '0;
      valid_w_q <= 1'b0;
    end else begin
      ctrl_e_q  <= ctrl_e_d;
      rd_e_q    <= rd_e_d;
      valid_e_q <= valid_e_d;
      we_m_q    <= ctrl_e_q[7];
      mwe_m_q   <= ctrl_e_q[2];
      wbsel_m_q <= ctrl_e_q[1];
      out_m_q   <= ctrl_e_q[0];
      rd_m_q    <= rd_e_q;
      valid_m_q <= valid_e_q;
      we_w_q    <= we_m_q;
      wbsel_w_q <= wbsel_m_q;
      rd_w_q    <= rd_m_q;
      valid_w_q <= valid_m_q;
    end
  end
`ifdef HAZARD_STALL_EN
  logic [STALLCNTWIDTH-1:0] stall_cnt_q;
  // a load in E whose destination feeds D stalls one cycle; a flush overrides it
  assign stallD = valid_e_q & ctrl_e_q[7] & ctrl_e_q[1] & ((rd_e_q == rs1D) | (rd_e_q == rs2D)) & ~flushE;
  // saturating count of stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else if (stallD & ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 1'b1;
  end
  assign stallCount = stall_cnt_q;
`else
  logic unused_rs;
  assign unused_rs  = ^{rs1D, rs2D};
  assign stallD     = 1'b0;
  assign stallCount = '0;
`endif
  assign aluControlE      = ctrl_e_q[5:3];
  assign data2SelectorE   = ctrl_e_q[6];
  assign rdE              = rd_e_q;
  assign validE           = valid_e_q;
  assign writeDataEnableM = mwe_m_q;
  assign outFlagM         = out_m_q;
  assign rdM              = rd_m_q;
  assign validM           = valid_m_q;
  assign resultSelectorW  = wbsel_w_q;
  assign writeEnableW     = we_w_q;
  assign rdW              = rd_w_q;
  assign validW           = valid_w_q;
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: scoreboard bench for pipe_control (OPCODEWIDTH=6, STALLCNTWIDTH=2)
module tb_pipe_control;
  localparam int OW = 6, RW = 4, SW = 2;
`ifdef HAZARD_STALL_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  typedef struct packed {
    logic [7:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       fl;
  } ins_t;
  logic clk = 1'b0, reset = 1'b0, flushE = 1'b0;
  logic [OW-1:0] opcodeD = '0;
  logic [RW-1:0] rdD = '0, rs1D = '0, rs2D = '0;
  logic [2:0] aluControlE;
  logic data2SelectorE, writeDataEnableM, outFlagM, resultSelectorW, writeEnableW;
  logic [RW-1:0] rdE, rdM, rdW;
  logic validE, validM, validW, stallD;
  logic [SW-1:0] stallCount;
  pipe_control #(.OPCODEWIDTH(OW), .REGADDRWIDTH(RW), .STALLCNTWIDTH(SW)) dut (
    .clk(clk), .reset(reset), .opcodeD(opcodeD), .rdD(rdD), .rs1D(rs1D), .rs2D(rs2D),
    .flushE(flushE), .aluControlE(aluControlE), .data2SelectorE(data2SelectorE),
    .writeDataEnableM(writeDataEnableM), .outFlagM(outFlagM), .resultSelectorW(resultSelectorW),
    .writeEnableW(writeEnableW), .rdE(rdE), .rdM(rdM), .rdW(rdW), .validE(validE),
    .validM(validM), .validW(validW), .stallD(stallD), .stallCount(stallCount)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cnt_exp = 0;
  logic [12:0] q[$];
  logic [12:0] e_exp = '0, m_exp = '0, w_exp = '0;
  ins_t prog[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] ref_dec(input logic [7:0] op);
    if (op > 8'd15) return 8'h00;
    case (op[3:0])
      4'h0: return 8'b0_0_000_0_0_0;
      4'h1: return 8'b0_0_110_1_0_0;
      4'h2: return 8'b1_1_111_0_0_0;
      4'h3: return 8'b1_0_110_0_0_0;
      4'h4: return 8'b0_0_110_0_0_1;
      4'h5: return 8'b1_0_000_0_0_0;
      4'h6: return 8'b1_0_001_0_0_0;
      4'h7: return 8'b1_0_110_0_1_0;
      4'h8: return 8'b1_0_010_0_0_0;
      4'h9: return 8'b1_0_101_0_0_0;
      4'hA: return 8'b0_0_001_0_0_0;
      default: return 8'b0_1_111_0_0_0;
    endcase
  endfunction
  task automatic chk_stages();
    chk("stageE", {validE, rdE, aluControlE, data2SelectorE}, {e_exp[12], e_exp[11:8], e_exp[5:3], e_exp[6]});
    chk("stageM", {validM, rdM, writeDataEnableM, outFlagM}, {m_exp[12], m_exp[11:8], m_exp[2], m_exp[0]});
    chk("stageW", {validW, rdW, writeEnableW, resultSelectorW}, {w_exp[12], w_exp[11:8], w_exp[7], w_exp[1]});
    chk("stallCount", stallCount, cnt_exp);
  endtask
  task automatic add(input int op, input int rd, input int rs1, input int rs2, input bit fl);
    prog.push_back({op[7:0], rd[3:0], rs1[3:0], rs2[3:0], fl});
  endtask
  // drive one instruction at the negedge, check, clock it, check, return at the next negedge
  task automatic step(input ins_t i, output bit adv);
    bit hz, st;
    opcodeD = i.op[OW-1:0];
    rdD = i.rd;
    rs1D = i.rs1;
    rs2D = i.rs2;
    flushE = i.fl;
    hz = HZ && e_exp[12] && e_exp[7] && e_exp[1] && (e_exp[11:8] == i.rs1 || e_exp[11:8] == i.rs2);
    st = hz && !i.fl;
    #1;
    chk("stallD", stallD, st);
    q.push_back((i.fl || st) ? 13'd0 : {1'b1, i.rd, ref_dec(i.op)});
    if (st && cnt_exp < (1 << SW) - 1) cnt_exp++;
    adv = !st;
    @(posedge clk);
    #1;
    w_exp = m_exp;
    m_exp = e_exp;
    if (q.size() == 0) chk("queue_empty", 1, 0);
    else e_exp = q.pop_front();
    chk_stages();
    @(negedge clk);
  endtask
  task automatic run_prog();
    bit adv;
    ins_t t;
    int budget = 4 * prog.size() + 4;
    while (prog.size() > 0) begin
      if (budget == 0) begin
        chk("cycle_budget", prog.size(), 0);
        prog.delete();
      end else begin
        budget--;
        step(prog[0], adv);
        if (adv) t = prog.pop_front();
      end
    end
  endtask
  // asynchronous reset between edges with a load in E and a dependent source on D
  task automatic mid_reset();
    opcodeD = 6'h05;
    rs1D = rdE;
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    e_exp = '0;
    m_exp = '0;
    w_exp = '0;
    cnt_exp = 0;
    chk("stallD_reset", stallD, 0);
    chk_stages();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #1 reset = 1'b1;
    #2;
    chk("stallD_reset", stallD, 0);
    chk_stages();
    @(negedge clk);
    reset = 1'b0;
    add(5, 3, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
    add(7, 2, 0, 0, 0); add(5, 4, 2, 0, 0);
    add(7, 5, 0, 0, 0); add(5, 6, 0, 5, 1);
    add(1, 0, 0, 0, 0); add(4, 0, 0, 0, 0); add(8'h15, 7, 0, 0, 0);
    add(2, 1, 0, 0, 0); add(3, 2, 0, 0, 0); add(6, 3, 0, 0, 0); add(8, 4, 0, 0, 0);
    add(9, 5, 0, 0, 0); add(10, 6, 0, 0, 0); add(11, 7, 0, 0, 0); add(15, 8, 0, 0, 0);
    add(7, 9, 0, 0, 0); add(7, 10, 0, 0, 0); add(7, 1, 0, 0, 0);
    run_prog();
    mid_reset();
    add(7, 1, 0, 0, 0); add(5, 0, 1, 0, 0);
    add(7, 2, 0, 0, 0); add(5, 0, 0, 2, 0);
    add(7, 3, 0, 0, 0); add(5, 0, 3, 3, 0);
    add(7, 4, 0, 0, 0); add(5, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
    run_prog();
    for (int k = 0; k < 40; k++)
      add($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 7) == 0);
    run_prog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter OPCODEWIDTH, default 4, opcode width; the SHALL be >= 4.
REQ-002 Parameter REGADDRWIDTH, default 4, register-address width.
REQ-003 Parameter STALLCNTWIDTH, default 8, stall-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 opcodeD  in  OPCODEWIDTH  decode-stage opcode.
REQ-007 rdD, rs1D, rs2D  in  REGADDRWIDTH each  decode-stage destination and source register addresses.
REQ-008 flushE  in  1  squash the instruction entering E (taken branch).
REQ-009 aluControlE  out  3  ALU operation, E stage.
REQ-010 data2SelectorE  out  1  ALU operand-2 source, E stage (1 = immediate).
REQ-011 writeDataEnableM  out  1  data-memory write enable, M stage.
REQ-012 outFlagM  out  1  output-port strobe, M stage.
REQ-013 resultSelectorW  out  1  write-back source, W stage (1 = memory).
REQ-014 writeEnableW  out  1  register-file write enable, W stage.
REQ-015 rdE, rdM, rdW  out  REGADDRWIDTH each  destination address per stage.
REQ-016 validE, validM, validW  out  1 each  stage holds a real instruction.
REQ-017 stallD  out  1  hold fetch/decode this cycle.
REQ-018 stallCount  out  STALLCNTWIDTH  saturating count of stall cycles.

Function
REQ-019 Decode SHALL be combinational from opcodeD to the bundle {we, src, alu, mwe, wbsel, out}; opcodes with any bit above bit 3 set SHALL decode as 0x0.
REQ-020 Table: 0x0 {0,0,000,0,0,0}; 0x1 {0,0,110,1,0,0}; 0x2 {1,1,111,0,0,0}; 0x3 {1,0,110,0,0,0}; 0x4 {0,0,110,0,0,1}; 0x5 {1,0,000,0,0,0}; 0x6 {1,0,001,0,0,0}; 0x7 {1,0,110,0,1,0}; 0x8 {1,0,010,0,0,0}; 0x9 {1,0,101,0,0,0}; 0xA {0,0,001,0,0,0}; 0xB-0xF {0,1,111,0,0,0}; no output SHALL ever be X.
REQ-021 Bubble SHALL be the 0x0 bundle with valid=0 and rd=0.
REQ-022 Each rising edge: E loads the decoded bundle, rdD and valid=1, unless a bubble is inserted; M loads E; W loads M; M and W SHALL never stall.
REQ-023 Bubble SHALL be inserted into E when flushE=1 or stallD=1.
REQ-024 Load-use hazard SHALL be: validE & weE & wbselE & (rdE==rs1D | rdE==rs2D).
REQ-025 stallD SHALL equal hazard & ~flushE, combinational, same cycle.
REQ-026 Simultaneous flushE and hazard: flush wins, one bubble, stallD=0, counter unchanged.
REQ-027 A hazard SHALL stall exactly one cycle; the following cycle the load is in M and the hazard condition is false.
REQ-028 stallCount SHALL increment on each edge where stallD=1 and hold at all-ones (saturate, no wrap).
REQ-029 Latency: opcode at D in cycle n SHALL appear on E outputs in n+1, M in n+2, W in n+3.

Reset
REQ-030 reset=1 SHALL immediately force E, M, W to bubble, stallCount to 0, stallD to 0, regardless of clk.
REQ-031 Reset mid-operation SHALL discard all in-flight instructions; first edge after release loads E from D normally.

Configuration
REQ-032 Macro HAZARD_STALL_EN defined: REQ-024..REQ-028 in force.
REQ-033 Macro HAZARD_STALL_EN undefined: stallD tied 0, stallCount tied 0, no counter register, bubbles only from flushE; all else unchanged.

Verification
REQ-034 Reset asserted mid-stream with loads in E/M -> all outputs 0 within same cycle, validE/M/W=0.
REQ-035 Opcode 0x5, rdD=3 at cycle 0 -> cycle 1 aluControlE=000, validE=1, rdE=3; cycle 3 writeEnableW=1, rdW=3, resultSelectorW=0.
REQ-036 0x7 rdD=2, then 0x5 rs1D=2 -> stallD=1 one cycle, E bubble, stallCount=1, add enters E next cycle (HAZARD_STALL_EN defined; undefined -> stallD=0, no bubble).
REQ-037 Same hazard with flushE=1 that cycle -> stallD=0, E bubble, stallCount=0.
REQ-038 STALLCNTWIDTH=2, four consecutive load-use pairs -> stallCount 1,2,3,3.
REQ-039 Opcode 0x1 then 0x4 -> writeDataEnableM=1 at cycle 2, outFlagM=1 at cycle 3, writeEnableW=0 for both; OPCODEWIDTH=6, opcode 0x15 -> NOP bundle.
